// File: rtl/mac_dot.sv
// Streaming dot-product MAC: accepts VEC_LEN operand pairs, multiplies in a
// registered stage, accumulates with wrap/saturate, and emits one result per vector.
module mac_dot #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 12,
    parameter int VEC_LEN    = 4,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  overflow
);

    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    localparam logic [ACC_WIDTH-1:0] U_MAX = '1;
    localparam logic [ACC_WIDTH-1:0] S_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] S_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM,
        FINISH,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]     count;
    logic [ACC_WIDTH-1:0] product;
    logic                 prod_valid;
    logic                 prod_last;
    logic [ACC_WIDTH-1:0] accumulator;
    logic                 ovf_sticky;

    logic                 in_fire;
    logic                 out_fire;
    logic                 is_last;

    logic [PROD_W-1:0]        mul_u;
    logic signed [PROD_W-1:0] mul_s;
    logic [ACC_WIDTH-1:0]     prod_ext;

    logic [ACC_WIDTH:0]   sum_wide;
    logic                 ovf_event;
    logic [ACC_WIDTH-1:0] sum_fixed;

    assign in_ready  = (state == ACCUM) && !reset;
    assign out_valid = (state == OUT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign is_last   = (count == LAST_IDX);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (in_fire && is_last) state_next = FINISH;
            // The last product is in stage 1 on entry; once it has retired, prod_valid drops.
            FINISH:  if (!prod_valid) state_next = OUT;
            OUT:     if (out_fire) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
            count <= '0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                count <= is_last ? '0 : count + CNT_W'(1);
            end
        end
    end

    // Stage 1: multiply and extend to the accumulator width.
    always_comb begin
        mul_u    = PROD_W'(operand_a) * PROD_W'(operand_b);
        mul_s    = PROD_W'($signed(operand_a)) * PROD_W'($signed(operand_b));
        prod_ext = ACC_WIDTH'(mul_u);
        if (SIGNED != 0) begin
            prod_ext = ACC_WIDTH'(mul_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            product    <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else begin
            prod_valid <= in_fire;
            if (in_fire) begin
                product   <= prod_ext;
                prod_last <= is_last;
            end
        end
    end

    // Stage 2: one extra bit exposes the carry (unsigned) or the sign flip (signed).
    always_comb begin
        if (SIGNED != 0) begin
            sum_wide  = {accumulator[ACC_WIDTH-1], accumulator} + {product[ACC_WIDTH-1], product};
            ovf_event = (accumulator[ACC_WIDTH-1] == product[ACC_WIDTH-1]) &&
                        (sum_wide[ACC_WIDTH-1] != accumulator[ACC_WIDTH-1]);
        end else begin
            sum_wide  = {1'b0, accumulator} + {1'b0, product};
            ovf_event = sum_wide[ACC_WIDTH];
        end

        sum_fixed = sum_wide[ACC_WIDTH-1:0];
        if (ovf_event && (SATURATE != 0)) begin
            if (SIGNED == 0) begin
                sum_fixed = U_MAX;
            end else if (accumulator[ACC_WIDTH-1]) begin
                sum_fixed = S_MIN;
            end else begin
                sum_fixed = S_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            accumulator <= '0;
            ovf_sticky  <= 1'b0;
            acc         <= '0;
            overflow    <= 1'b0;
        end else if (prod_valid) begin
            if (prod_last) begin
                acc         <= sum_fixed;
                overflow    <= ovf_sticky | ovf_event;
                accumulator <= '0;
                ovf_sticky  <= 1'b0;
            end else begin
                accumulator <= sum_fixed;
                ovf_sticky  <= ovf_sticky | ovf_event;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot.sv
// Bench for mac_dot: six configurations share one stimulus stream; a scoreboard
// of expected results from an integer reference model is popped as results appear.
module tb_mac_dot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] operand_a;
    logic [3:0] operand_b;

    logic        in_ready_v [6];
    logic        out_valid_v[6];
    logic        overflow_v [6];
    logic [11:0] acc_v      [6];
    logic [7:0]  acc8_1, acc8_2, acc8_4;

    assign acc_v[1] = {4'h0, acc8_1};
    assign acc_v[2] = {4'h0, acc8_2};
    assign acc_v[4] = {4'h0, acc8_4};

    // Reference-model view of each instance's configuration.
    localparam int ACCW[6] = '{12, 8, 8, 12, 8, 12};
    localparam int SGN [6] = '{0, 0, 0, 1, 1, 0};
    localparam int SAT [6] = '{0, 1, 0, 0, 1, 0};

    mac_dot #(.DATA_WIDTH(4), .ACC_WIDTH(12), .VEC_LEN(4), .SIGNED(0), .SATURATE(0)) u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .acc(acc_v[0]), .overflow(overflow_v[0]));

    mac_dot #(.DATA_WIDTH(4), .ACC_WIDTH(8), .VEC_LEN(4), .SIGNED(0), .SATURATE(1)) u_usat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .acc(acc8_1), .overflow(overflow_v[1]));

    mac_dot #(.DATA_WIDTH(4), .ACC_WIDTH(8), .VEC_LEN(4), .SIGNED(0), .SATURATE(0)) u_uwrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .acc(acc8_2), .overflow(overflow_v[2]));

    mac_dot #(.DATA_WIDTH(4), .ACC_WIDTH(12), .VEC_LEN(4), .SIGNED(1), .SATURATE(0)) u_sgn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid_v[3]),
        .out_ready(out_ready), .acc(acc_v[3]), .overflow(overflow_v[3]));

    mac_dot #(.DATA_WIDTH(4), .ACC_WIDTH(8), .VEC_LEN(4), .SIGNED(1), .SATURATE(1)) u_ssat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[4]),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid_v[4]),
        .out_ready(out_ready), .acc(acc8_4), .overflow(overflow_v[4]));

    mac_dot #(.DATA_WIDTH(4), .ACC_WIDTH(12), .VEC_LEN(1), .SIGNED(0), .SATURATE(0)) u_v1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[5]),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid_v[5]),
        .out_ready(out_ready), .acc(acc_v[5]), .overflow(overflow_v[5]));

    typedef struct {
        int          idx;
        logic [11:0] acc;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Integer-range reference: any partial sum outside the representable range overflows.
    function automatic void push_expected(input int idx, input int a[4], input int b[4], input int n);
        longint span, lo, hi, s, va, vb;
        logic   ovf;
        exp_t   e;
        span = longint'(1) << ACCW[idx];
        lo   = (SGN[idx] != 0) ? -(span / 2) : 0;
        hi   = (SGN[idx] != 0) ? (span / 2) - 1 : span - 1;
        s    = 0;
        ovf  = 1'b0;
        for (int i = 0; i < n; i++) begin
            va = longint'(a[i] & 15);
            vb = longint'(b[i] & 15);
            if (SGN[idx] != 0 && va >= 8) va = va - 16;
            if (SGN[idx] != 0 && vb >= 8) vb = vb - 16;
            s = s + va * vb;
            if (s > hi || s < lo) begin
                ovf = 1'b1;
                if (SAT[idx] != 0) s = (s > hi) ? hi : lo;
                else               s = (((s - lo) % span) + span) % span + lo;
            end
        end
        e.idx = idx;
        e.acc = 12'(s & (span - 1));
        e.ovf = ovf;
        sb.push_back(e);
    endfunction

    task automatic drive_vector(input int idx, input int a[4], input int b[4], input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            int k;
            bit got;
            operand_a = 4'(a[i]);
            operand_b = 4'(b[i]);
            in_valid  = 1'b1;
            k   = 0;
            got = 1'b0;
            while (!got && k < 50) begin
                got = in_ready_v[idx];
                @(posedge clk); #1;
                k++;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL accept_timeout idx=%0d elem=%0d accepted=0 want=1", idx, i);
            end
            if (bubbles && i != n - 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int idx, input int budget);
        int k = 0;
        while (!out_valid_v[idx] && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (out_valid_v[idx] !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout idx=%0d got=%b want=1", idx, out_valid_v[idx]);
        end
    endtask

    task automatic collect(input bit [5:0] mask, input int first);
        exp_t e;
        wait_valid(first, 30);
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty idx=%0d got=0 want=1", i);
                end else begin
                    e = sb.pop_front();
                    if (e.idx != i || acc_v[i] !== e.acc) begin
                        errors++;
                        $display("FAIL acc idx=%0d got=%0d want=%0d (entry idx %0d)", i, acc_v[i], e.acc, e.idx);
                    end
                    checks++;
                    if (overflow_v[i] !== e.ovf) begin
                        errors++;
                        $display("FAIL overflow idx=%0d got=%b want=%b", i, overflow_v[i], e.ovf);
                    end
                end
            end
        end
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b0 || out_valid_v[i] !== 1'b0 ||
                acc_v[i] !== 12'h000 || overflow_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state idx=%0d got in_ready=%b out_valid=%b acc=%0d ovf=%b want 0/0/0/0",
                         i, in_ready_v[i], out_valid_v[i], acc_v[i], overflow_v[i]);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset idx=%0d got=%b want=1", i, in_ready_v[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_default();
        int a[4], b[4];
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        push_expected(0, a, b, 4);
        drive_vector(0, a, b, 4, 1'b0);
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== (t == 2)) begin
                errors++;
                $display("FAIL latency cycle=%0d got in_ready=%b out_valid=%b want in_ready=0 out_valid=%b",
                         t, in_ready_v[0], out_valid_v[0], (t == 2));
            end
            if (t < 2) begin
                @(posedge clk); #1;
            end
        end
        collect(6'b000001, 0);
        checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL after_transfer got out_valid=%b in_ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
        end
    endtask

    task automatic test_overflow();
        int a[4], b[4];
        a = '{15, 15, 15, 15};
        b = '{15, 15, 15, 15};
        push_expected(0, a, b, 4);
        push_expected(1, a, b, 4);
        push_expected(2, a, b, 4);
        drive_vector(0, a, b, 4, 1'b0);
        collect(6'b000111, 0);
        a = '{1, 1, 1, 1};
        b = '{1, 1, 1, 1};
        push_expected(1, a, b, 4);
        push_expected(2, a, b, 4);
        drive_vector(1, a, b, 4, 1'b0);
        collect(6'b000110, 1);
    endtask

    task automatic test_signed();
        int a[4], b[4];
        a = '{-8, -8, 7, 1};
        b = '{7, -8, 7, -1};
        push_expected(3, a, b, 4);
        push_expected(4, a, b, 4);
        drive_vector(3, a, b, 4, 1'b0);
        collect(6'b011000, 3);
        a = '{-8, -8, -8, -8};
        b = '{-8, -8, -8, -8};
        push_expected(3, a, b, 4);
        push_expected(4, a, b, 4);
        drive_vector(3, a, b, 4, 1'b0);
        collect(6'b011000, 3);
    endtask

    task automatic test_backpressure();
        int   a[4], b[4];
        exp_t e;
        out_ready = 1'b0;
        a = '{9, 10, 11, 12};
        b = '{13, 14, 15, 3};
        push_expected(0, a, b, 4);
        drive_vector(0, a, b, 4, 1'b1);
        wait_valid(0, 30);
        e = sb.pop_front();
        in_valid  = 1'b1;
        operand_a = 4'hF;
        operand_b = 4'hF;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (acc_v[0] !== e.acc || overflow_v[0] !== e.ovf || out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle=%0d got acc=%0d ovf=%b out_valid=%b in_ready=%b want acc=%0d ovf=%b 1/0",
                         t, acc_v[0], overflow_v[0], out_valid_v[0], in_ready_v[0], e.acc, e.ovf);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got out_valid=%b in_ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
        end
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        push_expected(0, a, b, 4);
        drive_vector(0, a, b, 4, 1'b0);
        collect(6'b000001, 0);
    endtask

    task automatic test_reset_mid();
        int a[4], b[4];
        a = '{3, 3, 0, 0};
        b = '{3, 3, 0, 0};
        drive_vector(0, a, b, 2, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got=%b want=0", in_ready_v[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_vector got in_ready=%b out_valid=%b want 0/0", in_ready_v[0], out_valid_v[0]);
        end
        reset = 1'b0;
        #1;
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        push_expected(0, a, b, 4);
        drive_vector(0, a, b, 4, 1'b0);
        collect(6'b000001, 0);

        // Reset while a result is waiting in OUT discards it.
        out_ready = 1'b0;
        drive_vector(0, a, b, 4, 1'b0);
        wait_valid(0, 30);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || acc_v[0] !== 12'h000 || in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_out got out_valid=%b acc=%0d in_ready=%b want 0/0/1",
                     out_valid_v[0], acc_v[0], in_ready_v[0]);
        end
        out_ready = 1'b1;
        a = '{1, 1, 1, 1};
        b = '{1, 1, 1, 1};
        push_expected(0, a, b, 4);
        drive_vector(0, a, b, 4, 1'b0);
        collect(6'b000001, 0);
    endtask

    task automatic test_vec_len1();
        int a[4], b[4];
        int pa[2], pb[2];
        pa = '{2, 4};
        pb = '{3, 5};
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            a = '{pa[p], 0, 0, 0};
            b = '{pb[p], 0, 0, 0};
            push_expected(5, a, b, 1);
            drive_vector(5, a, b, 1, 1'b0);
            for (int t = 0; t < 2; t++) begin
                checks++;
                if (out_valid_v[5] !== 1'b0 || in_ready_v[5] !== 1'b0) begin
                    errors++;
                    $display("FAIL vl1_latency pair=%0d cycle=%0d got out_valid=%b in_ready=%b want 0/0",
                             p, t, out_valid_v[5], in_ready_v[5]);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (out_valid_v[5] !== 1'b1) begin
                errors++;
                $display("FAIL vl1_valid pair=%0d got=%b want=1", p, out_valid_v[5]);
            end
            collect(6'b100000, 5);
            checks++;
            if (in_ready_v[5] !== 1'b1) begin
                errors++;
                $display("FAIL vl1_ready pair=%0d got=%b want=1", p, in_ready_v[5]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_default();
        test_overflow();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_vec_len1();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
